// File: rtl/vsync_timing_recovery.sv
// vsync_timing_recovery: recovers vsync polarity, frame period and pulse width from a per-line sampled sync,
// locks after consistent frames and regenerates a line counter aligned to the sync leading edge.
module vsync_timing_recovery #(
  parameter int CW = 10,
  parameter int MAX_LINES = 1023,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clkv,
  input  logic          clrv,
  input  logic          line_stb,
  input  logic          vsync_in,
  output logic [CW-1:0] line_cnt,
  output logic [CW-1:0] frame_lines,
  output logic [CW-1:0] sync_width,
  output logic          vpol,
  output logic          frame_start,
  output logic          locked,
  output logic          err
);
  localparam logic [CW-1:0] MAXV = CW'(MAX_LINES);
  localparam logic [1:0] SEARCH = 2'd0, MEASURE = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3;
  logic s1, s, s_q, hi_v, lo_v, trans, lead, tmo, match, both_v;
  logic [1:0] state;
  logic [3:0] match_cnt;
  logic [CW-1:0] run_cnt, hi_len, lo_len, ref_period, ref_width, period, width, ref_sum, min_len;
  logic [CW:0] sum;
  always_comb begin
    both_v = hi_v && lo_v;
    trans = line_stb && (s != s_q);
    lead = trans && (s == vpol);
    tmo = line_stb && !trans && run_cnt == MAXV - CW'(1) && state != SEARCH;
    period = line_cnt == MAXV ? MAXV : line_cnt + CW'(1);
    width = vpol ? hi_len : lo_len;
    sum = {1'b0, hi_len} + {1'b0, lo_len};
    ref_sum = sum >= {1'b0, MAXV} ? MAXV : sum[CW-1:0];
    min_len = hi_len < lo_len ? hi_len : lo_len;
    // a saturated reference stands for a lost period and must never match
    match = period == ref_period && width == ref_width && ref_period != MAXV;
  end
  always_ff @(posedge clkv or negedge clrv) begin
    if (!clrv) begin
      {s1, s, s_q, hi_v, lo_v, vpol, frame_start, locked, err} <= '0;
      {line_cnt, frame_lines, sync_width, run_cnt, hi_len, lo_len, ref_period, ref_width} <= '0;
      state <= SEARCH;
      match_cnt <= '0;
    end else begin
      s1 <= vsync_in;
      s <= s1;
      err <= 1'b0;
      frame_start <= 1'b0;
      if (both_v) vpol <= hi_len < lo_len;
      if (state == SEARCH) {hi_v, lo_v} <= 2'b00;
      if (line_stb) begin
        s_q <= s;
        run_cnt <= trans ? CW'(1) : run_cnt == MAXV ? MAXV : run_cnt + CW'(1);
        line_cnt <= lead ? '0 : line_cnt == MAXV ? MAXV : line_cnt + CW'(1);
        frame_start <= lead;
      end
      if (trans && state != SEARCH && s_q) begin
        hi_len <= run_cnt;
        hi_v <= 1'b1;
      end
      if (trans && state != SEARCH && !s_q) begin
        lo_len <= run_cnt;
        lo_v <= 1'b1;
      end
      if (tmo) begin
        state <= SEARCH;
        locked <= 1'b0;
        err <= state == LOCKED;
      end else if (trans && state == SEARCH) begin
        state <= MEASURE;
      end else if (lead && state == MEASURE && both_v) begin
        ref_period <= ref_sum;
        ref_width <= min_len;
        match_cnt <= '0;
        state <= VERIFY;
      end else if (lead && state == VERIFY && match && match_cnt + 4'd1 == 4'(LOCK_FRAMES)) begin
        locked <= 1'b1;
        frame_lines <= ref_period;
        sync_width <= ref_width;
        state <= LOCKED;
      end else if (lead && state == VERIFY && match) begin
        match_cnt <= match_cnt + 4'd1;
      end else if (lead && (state == VERIFY || state == LOCKED) && !match) begin
        ref_period <= period;
        ref_width <= width;
        match_cnt <= '0;
        locked <= 1'b0;
        err <= state == LOCKED;
        state <= VERIFY;
      end
    end
  end
endmodule

// File: doc/vsync_timing_recovery.md
Name: vsync_timing_recovery

Overview:
Receive-side counterpart of the vertical sync generator. It takes an incoming vertical sync level, sampled once per line, and works out the sync polarity, the frame period in lines and the sync pulse width. It locks after consistent frames and regenerates a line counter aligned to the sync leading edge. It sits at the video input, ahead of capture/overlay logic, which uses `locked`, `line_cnt` and `frame_start`.

Parameters:
- CW, 10, width of all line counters/measurements.
- MAX_LINES, 1023, run/period timeout in lines; counters saturate here.
- LOCK_FRAMES, 2, consecutive matching frames required to lock (1..15).

Ports:
- clkv, input, 1, system clock; all state on rising edge.
- clrv, input, 1, reset: asynchronous, active-low.
- line_stb, input, 1, one-cycle strobe per video line.
- vsync_in, input, 1, incoming vertical sync (asynchronous to clkv).
- line_cnt, output, CW, lines since last sync leading edge.
- frame_lines, output, CW, locked-in frame period in lines.
- sync_width, output, CW, locked-in sync pulse width in lines.
- vpol, output, 1, 1 = active-high sync pulse.
- frame_start, output, 1, one-cycle pulse at sync leading edge.
- locked, output, 1, timing stable.
- err, output, 1, one-cycle pulse on loss of lock or timeout while locked.

Behaviour:
- Reset (clrv=0, async): all outputs 0, FSM=SEARCH, internal counters 0, synchronizer flops 0.
- vsync_in passes a 2-flop synchronizer. vsync_in must be stable ≥3 clkv before line_stb.
- Sampling:
  - Only on cycles with line_stb=1 is the synchronized value `s` captured into `s_q`.
  - Transition = `s` != `s_q` on a line_stb cycle.
  - Nothing updates when line_stb=0.
- Run counting:
  - run_cnt counts line_stb since the last transition and reloads to 1 on a transition.
  - On a transition, the finished run length is stored in hi_len (if `s_q`=1) or lo_len.
- Polarity: vpol = (hi_len < lo_len). It is evaluated when both runs are valid; ties give vpol=0.
- Leading edge = transition where new `s` == vpol. Trailing edge = transition where new `s` != vpol.
- Line counter and frame_start:
  - On a leading edge, line_cnt <= 0 and frame_start pulses for that one registered cycle.
  - Otherwise line_cnt increments per line_stb, saturating at MAX_LINES.
- Per-edge measurement: on each leading edge, period = line_cnt+1 and width = last pulse-run length.
- FSM:
  - SEARCH:
    - On the first transition, go to MEASURE.
    - hi_len/lo_len are invalidated.
  - MEASURE:
    - Wait until hi_len and lo_len are both valid, then wait for the next leading edge.
    - At that edge, ref_period = hi_len+lo_len and ref_width = min(hi_len, lo_len).
    - Then go to VERIFY with match_cnt=0.
  - VERIFY, at each leading edge:
    - If period==ref_period and width==ref_width, match_cnt++.
    - When match_cnt reaches LOCK_FRAMES: locked<=1, frame_lines<=ref_period, sync_width<=ref_width, go to LOCKED.
    - On a mismatch, reload refs from this measurement and set match_cnt=0.
  - LOCKED, at each leading edge:
    - On a match, stay.
    - On a mismatch, err=1 for one cycle, locked<=0, refs reloaded, match_cnt=0, go to VERIFY.
    - frame_lines and sync_width hold their last locked values.
- Timeout:
  - If run_cnt reaches MAX_LINES in any state other than SEARCH, go to SEARCH and set locked<=0.
  - err pulses only if the FSM was in LOCKED.
  - run_cnt saturates, and there is no repeated err while sync stays stuck.
- Simultaneous events: a transition on the same line_stb that run_cnt would hit MAX_LINES takes the transition; no timeout.
- A vsync polarity change while LOCKED is a mismatch, handled per LOCKED above (vpol re-evaluates from the new runs).
- Arithmetic: all CW-bit unsigned. hi_len+lo_len saturates at MAX_LINES; a saturated ref never matches.

Test Plan:
- Period 529 lines, vsync high for lines 525..528, low otherwise, LOCK_FRAMES=2:
  - vpol=1, ref_period=529, ref_width=4.
  - locked=1 at the 2nd leading edge after the FSM enters VERIFY.
  - frame_lines=529, sync_width=4.
  - frame_start every 529 line_stb; line_cnt wraps 528->0.
- Same timing but inverted (low pulse of 4) -> vpol=0; lock behaviour and values identical.
- While locked, one frame shortened to 528 lines -> err pulses once, locked=0. With 529 lines restored, relock requires LOCK_FRAMES consecutive matches; frame_lines stays 529 throughout.
- While locked, hold vsync_in low permanently -> after 1023 line_stb: locked=0, single err pulse, FSM=SEARCH, line_cnt saturates at 1023.
- Assert clrv=0 mid-frame (between line_stb pulses) -> all outputs 0 immediately, without a clkv edge. After release, the full relock sequence is required.
- Toggle vsync_in with line_stb held low for 100 cycles -> no output or state changes.
